// File: rtl/dhu_pkg.sv
// Shared types, codes and helpers for the decode-stage hazard unit.
// Optional signed compare modes are enabled by defining DHU_SIGNED_CMP_EN.
package dhu_pkg;

  localparam int TW = 2;

  typedef enum logic [2:0] {
    FW_NONE = 3'd0,
    FW_M    = 3'd1,
    FW_W    = 3'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'd0,
    CMP_NE  = 2'd1,
    CMP_LT  = 2'd2,
    CMP_GEZ = 2'd3
  } cmp_mode_e;

  // $0 is hardwired to zero, so a write to it never creates a dependency
  function automatic logic regMatch(input logic [4:0] r, input logic we, input logic [4:0] wreg);
    return (r != 5'd0) && we && (wreg == r);
  endfunction

  function automatic fwd_sel_e fwdSel(input logic [4:0] r,
                                      input logic mWe, input logic [4:0] mWreg,
                                      input logic [TW-1:0] mTNew,
                                      input logic wWe, input logic [4:0] wWreg);
    if (regMatch(r, mWe, mWreg) && (mTNew == '0))
      return FW_M;
    else if (regMatch(r, wWe, wWreg))
      return FW_W;
    return FW_NONE;
  endfunction

endpackage

// File: rtl/dhu_if.sv
// Bundle of pipeline-side signals seen by the decode hazard unit.
// master = pipeline datapath, slave = decode_hazard_unit.
interface dhu_if #(parameter int CNT_W = 32);
  import dhu_pkg::*;

  logic [TW-1:0]    T_use_rs, T_use_rt, E_T_new, M_T_new;
  logic [4:0]       E_Wreg, M_Wreg, W_Wreg;
  logic             E_GRF_WE, M_GRF_WE, W_GRF_WE;
  logic [4:0]       D_rs, D_rt, E_rs, E_rt, M_rt;
  logic             stall;
  logic [2:0]       s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data;
  logic [31:0]      D_Rdata1, D_Rdata2;
  logic [1:0]       s_D_cmp;
  logic             D_equal;
  logic [15:0]      D_imm16;
  logic [25:0]      D_imm26;
  logic [31:0]      D_pc, D_adder;
  logic [31:0]      D_imm16_EXT, D_imm26_EXT, D_br_target;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output T_use_rs, T_use_rt, E_T_new, M_T_new, E_Wreg, M_Wreg, W_Wreg,
           E_GRF_WE, M_GRF_WE, W_GRF_WE, D_rs, D_rt, E_rs, E_rt, M_rt,
           D_Rdata1, D_Rdata2, s_D_cmp, D_imm16, D_imm26, D_pc, D_adder,
    input  stall, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data,
           D_equal, D_imm16_EXT, D_imm26_EXT, D_br_target, stall_cnt
  );

  modport slave (
    input  T_use_rs, T_use_rt, E_T_new, M_T_new, E_Wreg, M_Wreg, W_Wreg,
           E_GRF_WE, M_GRF_WE, W_GRF_WE, D_rs, D_rt, E_rs, E_rt, M_rt,
           D_Rdata1, D_Rdata2, s_D_cmp, D_imm16, D_imm26, D_pc, D_adder,
    output stall, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data,
           D_equal, D_imm16_EXT, D_imm26_EXT, D_br_target, stall_cnt
  );

endinterface

// File: rtl/dhu_branch_cmp.sv
// Branch condition comparator for the decode stage.
// Signed modes (LT, GEZ) exist only when DHU_SIGNED_CMP_EN is defined; otherwise they read as not-taken.
module dhu_branch_cmp
  import dhu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  mode_i,
  output logic        taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (mode_i)
      CMP_EQ:  taken_o = (a_i == b_i);
      CMP_NE:  taken_o = (a_i != b_i);
`ifdef DHU_SIGNED_CMP_EN
      CMP_LT:  taken_o = ($signed(a_i) < $signed(b_i));
      CMP_GEZ: taken_o = ~a_i[31];
`endif
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode-stage hazard/forwarding unit, branch comparator and immediate extender.
// Define DHU_SIGNED_CMP_EN to enable the signed branch compare modes.
module decode_hazard_unit
  import dhu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic  clk,
  input  logic  reset,
  dhu_if.slave  bus
);

  logic             stallRs, stallRt;
  logic [31:0]      immExt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             unusedPcBits;

  // A consumer stalls when a producer in E or M will not have its result in time
  assign stallRs = (regMatch(bus.D_rs, bus.E_GRF_WE, bus.E_Wreg) && (bus.E_T_new > bus.T_use_rs)) ||
                   (regMatch(bus.D_rs, bus.M_GRF_WE, bus.M_Wreg) && (bus.M_T_new > bus.T_use_rs));
  assign stallRt = (regMatch(bus.D_rt, bus.E_GRF_WE, bus.E_Wreg) && (bus.E_T_new > bus.T_use_rt)) ||
                   (regMatch(bus.D_rt, bus.M_GRF_WE, bus.M_Wreg) && (bus.M_T_new > bus.T_use_rt));
  assign bus.stall = stallRs || stallRt;

  assign bus.s_D_rs_data = fwdSel(bus.D_rs, bus.M_GRF_WE, bus.M_Wreg, bus.M_T_new, bus.W_GRF_WE, bus.W_Wreg);
  assign bus.s_D_rt_data = fwdSel(bus.D_rt, bus.M_GRF_WE, bus.M_Wreg, bus.M_T_new, bus.W_GRF_WE, bus.W_Wreg);
  assign bus.s_E_rs_data = fwdSel(bus.E_rs, bus.M_GRF_WE, bus.M_Wreg, bus.M_T_new, bus.W_GRF_WE, bus.W_Wreg);
  assign bus.s_E_rt_data = fwdSel(bus.E_rt, bus.M_GRF_WE, bus.M_Wreg, bus.M_T_new, bus.W_GRF_WE, bus.W_Wreg);

  // M-stage store data has a single bypass source (W), selected by code 1
  assign bus.s_M_rt_data = regMatch(bus.M_rt, bus.W_GRF_WE, bus.W_Wreg) ? 3'd1 : 3'd0;

  dhu_branch_cmp uCmp (
    .a_i     (bus.D_Rdata1),
    .b_i     (bus.D_Rdata2),
    .mode_i  (bus.s_D_cmp),
    .taken_o (bus.D_equal)
  );

  assign immExt          = {{16{bus.D_imm16[15]}}, bus.D_imm16};
  assign bus.D_imm16_EXT = immExt;
  assign bus.D_imm26_EXT = {bus.D_pc[31:28], bus.D_imm26, 2'b00};
  assign bus.D_br_target = bus.D_adder + {immExt[29:0], 2'b00};
  assign unusedPcBits    = ^bus.D_pc[27:0];

  // Stall-cycle counter saturates instead of wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Scoreboard testbench for decode_hazard_unit: directed and random vectors against a reference model.
module tb_decode_hazard_unit;
  import dhu_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic [1:0]  tUseRs, tUseRt, eTNew, mTNew;
    logic [4:0]  eWreg, mWreg, wWreg;
    logic        eWe, mWe, wWe;
    logic [4:0]  dRs, dRt, eRs, eRt, mRt;
    logic [31:0] r1, r2;
    logic [1:0]  cmp;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc, adder;
  } vec_t;

  typedef struct packed {
    logic          stall;
    logic [2:0]    sDrs, sDrt, sErs, sErt, sMrt;
    logic          eq;
    logic [31:0]   imm16Ext, imm26Ext, brT;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t expQ[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;
  int   modelCnt = 0;

  always #5 clk = ~clk;

  dhu_if #(.CNT_W(CW)) bus ();

  decode_hazard_unit #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model derived from the pipeline timing rules
  function automatic int fwdRef(input int r, input vec_t v);
    if (r == 0) return 0;
    if (v.mWe && int'(v.mWreg) == r && v.mTNew == 0) return 1;
    if (v.wWe && int'(v.wWreg) == r) return 2;
    return 0;
  endfunction

  function automatic logic needStall(input int r, input int tUse, input vec_t v);
    if (r == 0) return 1'b0;
    if (v.eWe && int'(v.eWreg) == r && int'(v.eTNew) > tUse) return 1'b1;
    if (v.mWe && int'(v.mWreg) == r && int'(v.mTNew) > tUse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t modelOf(input vec_t v);
    exp_t e = '0;
    int   imm;
    e.stall = needStall(int'(v.dRs), int'(v.tUseRs), v) || needStall(int'(v.dRt), int'(v.tUseRt), v);
    e.sDrs  = 3'(fwdRef(int'(v.dRs), v));
    e.sDrt  = 3'(fwdRef(int'(v.dRt), v));
    e.sErs  = 3'(fwdRef(int'(v.eRs), v));
    e.sErt  = 3'(fwdRef(int'(v.eRt), v));
    e.sMrt  = (v.mRt != 0 && v.wWe && v.wWreg == v.mRt) ? 3'd1 : 3'd0;
    case (v.cmp)
      2'd0: e.eq = (v.r1 == v.r2);
      2'd1: e.eq = (v.r1 != v.r2);
`ifdef DHU_SIGNED_CMP_EN
      2'd2: e.eq = ($signed(v.r1) < $signed(v.r2));
      2'd3: e.eq = ($signed(v.r1) >= 0);
`endif
      default: e.eq = 1'b0;
    endcase
    imm        = int'($signed(v.imm16));
    e.imm16Ext = 32'(imm);
    e.brT      = v.adder + 32'(imm * 4);
    e.imm26Ext = (v.pc & 32'hF000_0000) | (32'(v.imm26) << 2);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.T_use_rs = v.tUseRs;  bus.T_use_rt = v.tUseRt;
    bus.E_T_new  = v.eTNew;   bus.M_T_new  = v.mTNew;
    bus.E_Wreg   = v.eWreg;   bus.M_Wreg   = v.mWreg;   bus.W_Wreg = v.wWreg;
    bus.E_GRF_WE = v.eWe;     bus.M_GRF_WE = v.mWe;     bus.W_GRF_WE = v.wWe;
    bus.D_rs     = v.dRs;     bus.D_rt     = v.dRt;
    bus.E_rs     = v.eRs;     bus.E_rt     = v.eRt;     bus.M_rt = v.mRt;
    bus.D_Rdata1 = v.r1;      bus.D_Rdata2 = v.r2;      bus.s_D_cmp = v.cmp;
    bus.D_imm16  = v.imm16;   bus.D_imm26  = v.imm26;
    bus.D_pc     = v.pc;      bus.D_adder  = v.adder;
    e = modelOf(v);
    e.cnt = CW'(modelCnt);
    expQ.push_back(e);
    if (!reset && e.stall && modelCnt < (1 << CW) - 1)
      modelCnt++;
  endtask

  task automatic nextCycle(input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
  endtask

  // Monitor: every cycle with a pending vector is compared at the falling edge
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      got = expQ.pop_front();
      checkOutput("stall",       32'(bus.stall),       32'(got.stall));
      checkOutput("s_D_rs_data", 32'(bus.s_D_rs_data), 32'(got.sDrs));
      checkOutput("s_D_rt_data", 32'(bus.s_D_rt_data), 32'(got.sDrt));
      checkOutput("s_E_rs_data", 32'(bus.s_E_rs_data), 32'(got.sErs));
      checkOutput("s_E_rt_data", 32'(bus.s_E_rt_data), 32'(got.sErt));
      checkOutput("s_M_rt_data", 32'(bus.s_M_rt_data), 32'(got.sMrt));
      checkOutput("D_equal",     32'(bus.D_equal),     32'(got.eq));
      checkOutput("D_imm16_EXT", bus.D_imm16_EXT,      got.imm16Ext);
      checkOutput("D_imm26_EXT", bus.D_imm26_EXT,      got.imm26Ext);
      checkOutput("D_br_target", bus.D_br_target,      got.brT);
      checkOutput("stall_cnt",   32'(bus.stall_cnt),   32'(got.cnt));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    vec_t lwStall;

    lwStall        = '0;
    lwStall.eWreg  = 5'd8;
    lwStall.eWe    = 1'b1;
    lwStall.eTNew  = 2'd2;
    lwStall.dRs    = 5'd8;
    lwStall.dRt    = 5'd9;

    reset = 1'b1;
    applyStimulus('0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Counter runs for five stall cycles, then an async reset clears it between edges
    for (int i = 0; i < 5; i++) nextCycle(lwStall);
    @(posedge clk);
    #1;
    checkOutput("cnt after 5 stalls", 32'(bus.stall_cnt), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("cnt async clear", 32'(bus.stall_cnt), 32'd0);
    reset = 1'b0;
    modelCnt = 0;
    applyStimulus('0);

    nextCycle(lwStall);
    nextCycle('0);
    checkOutput("cnt after lw stall", 32'(bus.stall_cnt), 32'd1);

    v = '0; v.mWreg = 5'd5; v.mWe = 1'b1; v.dRs = 5'd5; v.tUseRs = 2'd1;
    nextCycle(v);
    v = '0; v.mWreg = 5'd5; v.mWe = 1'b1; v.wWreg = 5'd5; v.wWe = 1'b1; v.eRs = 5'd5;
    nextCycle(v);
    v.mWreg = 5'd6;
    nextCycle(v);
    v = '0; v.wWe = 1'b1; v.wWreg = 5'd0; v.dRs = 5'd0; v.mRt = 5'd0;
    nextCycle(v);
    v = '0; v.r1 = 32'h1234; v.r2 = 32'h1234; v.cmp = 2'd0;
    nextCycle(v);
    v.cmp = 2'd1;
    nextCycle(v);
    v = '0; v.imm16 = 16'hFFFF; v.adder = 32'h3004; v.pc = 32'hA000_3000; v.imm26 = 26'h3FF_FFFF;
    nextCycle(v);

    for (int i = 0; i < 300; i++) begin
      v        = '0;
      v.tUseRs = 2'($urandom_range(0, 3));
      v.tUseRt = 2'($urandom_range(0, 3));
      v.eTNew  = 2'($urandom_range(0, 3));
      v.mTNew  = 2'($urandom_range(0, 3));
      v.eWreg  = 5'($urandom_range(0, 3));
      v.mWreg  = 5'($urandom_range(0, 3));
      v.wWreg  = 5'($urandom_range(0, 3));
      v.eWe    = 1'($urandom_range(0, 1));
      v.mWe    = 1'($urandom_range(0, 1));
      v.wWe    = 1'($urandom_range(0, 1));
      v.dRs    = 5'($urandom_range(0, 3));
      v.dRt    = 5'($urandom_range(0, 3));
      v.eRs    = 5'($urandom_range(0, 3));
      v.eRt    = 5'($urandom_range(0, 3));
      v.mRt    = 5'($urandom_range(0, 3));
      v.r1     = $urandom;
      v.r2     = ($urandom_range(0, 3) == 0) ? v.r1 : $urandom;
      v.cmp    = 2'($urandom_range(0, 3));
      v.imm16  = 16'($urandom);
      v.imm26  = 26'($urandom);
      v.pc     = $urandom;
      v.adder  = $urandom;
      nextCycle(v);
    end

    // Long stall run drives the narrow counter into saturation
    for (int i = 0; i < 20; i++) nextCycle(lwStall);
    @(posedge clk);
    #1;
    checkOutput("cnt saturated", 32'(bus.stall_cnt), 32'((1 << CW) - 1));
    applyStimulus('0);

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
